temporizador_alarme: RTL and testbench

TEMPORIZADOR_ALARME -- requirements
Module: temporizador_alarme

---
 rtl/temporizador_alarme.sv | 172 +++++++++++++++++
 tb/tb_temporizador_alarme.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/temporizador_alarme.sv
// -----------------------------------------------------------------------------
// temporizador_alarme
//
// Countdown alarm timer. The timer counts in periods of a slow clock
// (clock_in) that is asynchronous to Clock. A start request loads a delay.
// Each rising edge of the slow clock then decrements the remaining count.
// When the count reaches zero the timer raises expired for one cycle.
//
// Optional feature (macro CLOCK_LOST_DETECT_EN):
//   This feature watches for a missing slow clock. If no tick arrives for
//   LOST_LIMIT Clock cycles, clock_lost is raised. A countdown in progress is
//   then abandoned, and start requests are refused until ticks resume.
//   When the macro is not defined, clock_lost is tied to 0 and no loss
//   counter exists.
//
// Parameters
//   SEG_W       width of delay / remaining
//   LOST_LIMIT  Clock cycles without a tick before clock_lost asserts
//
// Ports
//   Clock       system clock, rising-edge active
//   Reset_n     asynchronous active-low reset
//   clock_in    slow clock, asynchronous to Clock
//   start       one-cycle request to load delay and begin counting
//   cancel      abort request (priority over start and tick)
//   delay       countdown length in slow-clock periods
//   tick        one-cycle pulse per rising edge of clock_in
//   busy        high while counting
//   expired     one-cycle pulse on countdown completion
//   remaining   slow periods left
//   clock_lost  slow clock absent (constant 0 unless CLOCK_LOST_DETECT_EN)
// -----------------------------------------------------------------------------
module temporizador_alarme #(
   parameter int SEG_W      = 8,
   parameter int LOST_LIMIT = 100000000
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             clock_in,
   input  logic             start,
   input  logic             cancel,
   input  logic [SEG_W-1:0] delay,
   output logic             tick,
   output logic             busy,
   output logic             expired,
   output logic [SEG_W-1:0] remaining,
   output logic             clock_lost
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [SEG_W-1:0] remaining_reg, remaining_next;

   logic [1:0]       sync_reg;   // [0] first stage, [1] second stage
   logic             hist_reg;
   logic [1:0]       arm_reg;
   logic             armed;
   logic             lost_now;

   // Slow-clock synchronizer, history flop and edge detect.
   // arm_reg holds tick off for the first three cycles after reset
   // release. During that time the history flop catches up with the
   // synchronized level. Without this hold, a clock_in that is already
   // high at release would look like a rising edge.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_reg <= '0;
         hist_reg <= 1'b0;
         arm_reg  <= '0;
      end else begin
         sync_reg <= {sync_reg[0], clock_in};
         hist_reg <= sync_reg[1];
         if (arm_reg != 2'd3)
            arm_reg <= arm_reg + 2'd1;
      end
   end

   assign armed = (arm_reg == 2'd3);
   assign tick  = armed & sync_reg[1] & ~hist_reg;

`ifdef CLOCK_LOST_DETECT_EN
   localparam int LW = $clog2(LOST_LIMIT + 1);

   logic [LW-1:0] lost_cnt_reg;

   // Cycles since the last tick. The counter saturates at LOST_LIMIT, so
   // clock_lost stays high until the next tick clears it.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)
         lost_cnt_reg <= '0;
      else if (tick)
         lost_cnt_reg <= '0;
      else if (lost_cnt_reg != LW'(LOST_LIMIT))
         lost_cnt_reg <= lost_cnt_reg + LW'(1);
   end

   assign lost_now = (lost_cnt_reg == LW'(LOST_LIMIT));
`else
   // Without loss detection the limit has no effect, and clock_lost is 0.
   if (LOST_LIMIT > 0) begin : g_no_lost_detect
      assign lost_now = 1'b0;
   end else begin : g_no_lost_detect_zero_limit
      assign lost_now = 1'b0;
   end
`endif

   assign clock_lost = lost_now;

   // State register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      case (state_reg)
         IDLE: begin
            // cancel beats start. A lost slow clock also refuses start.
            if (!cancel && start && !lost_now) begin
               if (delay != '0) begin
                  state_next     = COUNT;
                  remaining_next = delay;
               end else begin
                  state_next     = DONE;
                  remaining_next = '0;
               end
            end
         end
         COUNT: begin
            if (cancel || lost_now) begin
               state_next     = IDLE;
               remaining_next = '0;
            end else if (tick) begin
               // A remaining of 1 (or 0, which should not occur) ends the
               // count. The count never wraps below zero.
               if (remaining_reg <= SEG_W'(1)) begin
                  state_next     = DONE;
                  remaining_next = '0;
               end else begin
                  remaining_next = remaining_reg - SEG_W'(1);
               end
            end
         end
         DONE: begin
            // expired is already asserted. cancel/start cannot stop it.
            state_next = IDLE;
         end
         default: begin
            state_next     = IDLE;
            remaining_next = '0;
         end
      endcase
   end

   assign busy      = (state_reg == COUNT);
   assign expired   = (state_reg == DONE);
   assign remaining = remaining_reg;

endmodule

// File: tb/tb_temporizador_alarme.sv
// -----------------------------------------------------------------------------
// tb_temporizador_alarme
//
// Randomized bench for temporizador_alarme. The stimulus process drives
// inputs once per cycle, just after the rising edge. It then computes the
// expected outputs for that cycle from a behavioural model and queues them.
// A separate monitor pops one entry on every falling edge and compares it
// with the DUT outputs.
//
// The behavioural model works as follows:
//   - clock_in samples are logged per cycle. A tick is expected two cycles
//     after a logged 0->1 transition, but not in the first 3 cycles after
//     reset release.
//   - The countdown is an integer with an "active" flag and a "fire" flag.
//   - Loss detection is a count of cycles since the last expected tick.
//     It is compared against LIMIT, and only applies when
//     CLOCK_LOST_DETECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_temporizador_alarme;

   localparam int SEG_W = 8;
   localparam int LIMIT = 50;
   localparam int NCYC  = 4000;

`ifdef CLOCK_LOST_DETECT_EN
   localparam bit LOST_EN = 1'b1;
`else
   localparam bit LOST_EN = 1'b0;
`endif

   logic             Clock    = 1'b0;
   logic             Reset_n  = 1'b0;
   logic             clock_in = 1'b0;
   logic             start    = 1'b0;
   logic             cancel   = 1'b0;
   logic [SEG_W-1:0] delay    = '0;
   logic             tick;
   logic             busy;
   logic             expired;
   logic [SEG_W-1:0] remaining;
   logic             clock_lost;

   always #5 Clock = ~Clock;

   temporizador_alarme #(
      .SEG_W      (SEG_W),
      .LOST_LIMIT (LIMIT)
   ) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .clock_in   (clock_in),
      .start      (start),
      .cancel     (cancel),
      .delay      (delay),
      .tick       (tick),
      .busy       (busy),
      .expired    (expired),
      .remaining  (remaining),
      .clock_lost (clock_lost)
   );

   typedef struct packed {
      logic [31:0]      cyc;
      logic             tick;
      logic             busy;
      logic             expired;
      logic             lost;
      logic [SEG_W-1:0] rem;
   } obs_t;

   obs_t exp_q[$];
   obs_t mon_e;

   int total        = 0;
   int bad          = 0;
   int exp_expired  = 0;
   int got_expired  = 0;

   // Monitor: one comparison per cycle against the queued expectation
   initial begin
      forever begin
         @(negedge Clock);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (expired)
               got_expired++;
            if ({tick, busy, expired, clock_lost, remaining} !==
                {mon_e.tick, mon_e.busy, mon_e.expired, mon_e.lost, mon_e.rem}) begin
               bad++;
               $display("FAIL cycle_outputs cyc=%0d got tick=%b busy=%b expired=%b lost=%b rem=%0d want tick=%b busy=%b expired=%b lost=%b rem=%0d",
                        mon_e.cyc, tick, busy, expired, clock_lost, remaining,
                        mon_e.tick, mon_e.busy, mon_e.expired, mon_e.lost, mon_e.rem);
            end else if (mon_e.expired) begin
               $display("cyc=%0d expired pulse ok", mon_e.cyc);
            end
         end
      end
   end

   // Stimulus and behavioural reference model
   bit ci_log [0:NCYC-1];
   int rst_hold;
   int rel_cyc;
   bit was_low;
   bit did_rst;
   int half_per;
   int ph;
   int mode;
   // model state
   bit m_active;
   bit m_fire;
   int m_left;
   int m_quiet;
   bit m_tick;
   bit m_lost;
   obs_t e;

   initial begin
      rst_hold = 4;
      rel_cyc  = 0;
      was_low  = 1'b1;
      did_rst  = 1'b0;
      half_per = 10;
      ph       = 0;
      mode     = 0;
      m_active = 1'b0;
      m_fire   = 1'b0;
      m_left   = 0;
      m_quiet  = 0;

      for (int n = 0; n < NCYC; n++) begin
         @(posedge Clock);
         #1;

         // clock_in pattern: alternating 150-cycle segments of
         // period 20, random period, or frozen (long enough to trip loss).
         if (n % 150 == 0) begin
            mode = (n < 300) ? 0 : int'($urandom_range(0, 2));
            half_per = (mode == 1) ? int'($urandom_range(2, 15)) : 10;
         end
         if (mode != 2) begin
            ph++;
            if (ph >= half_per) begin
               ph = 0;
               clock_in = ~clock_in;
            end
         end

         // Occasional reset while counting with clock_in high
         if (rst_hold == 0 && m_active && clock_in &&
             ((!did_rst && n > 1500) || $urandom_range(0, 299) == 0)) begin
            rst_hold = int'($urandom_range(1, 3));
            did_rst  = 1'b1;
         end
         if (rst_hold > 0) begin
            Reset_n = 1'b0;
            rst_hold--;
         end else begin
            Reset_n = 1'b1;
         end

         start  = ($urandom_range(0, 11) == 0);
         cancel = ($urandom_range(0, 39) == 0);
         delay  = ($urandom_range(0, 7) == 0) ? '0 : SEG_W'($urandom_range(1, 7));

         if (!Reset_n) begin
            ci_log[n] = 1'b0;
            m_active  = 1'b0;
            m_fire    = 1'b0;
            m_left    = 0;
            m_quiet   = 0;
            was_low   = 1'b1;
            e = '{cyc: n, tick: 1'b0, busy: 1'b0, expired: 1'b0, lost: 1'b0, rem: '0};
            exp_q.push_back(e);
         end else begin
            if (was_low) begin
               rel_cyc = n;
               was_low = 1'b0;
            end
            ci_log[n] = clock_in;
            m_tick = (n - rel_cyc >= 3) && ci_log[n-2] && !ci_log[n-3];
            m_lost = LOST_EN && (m_quiet >= LIMIT);

            e = '{cyc: n, tick: m_tick, busy: m_active, expired: m_fire,
                  lost: m_lost, rem: SEG_W'(m_left)};
            exp_q.push_back(e);
            if (m_fire)
               exp_expired++;

            // advance the model to the next cycle
            if (m_fire) begin
               m_fire = 1'b0;
            end else if (m_active) begin
               if (cancel || m_lost) begin
                  m_active = 1'b0;
                  m_left   = 0;
               end else if (m_tick) begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_active = 1'b0;
                     m_fire   = 1'b1;
                  end
               end
            end else if (start && !cancel && !m_lost) begin
               if (delay == '0) begin
                  m_fire = 1'b1;
                  m_left = 0;
               end else begin
                  m_active = 1'b1;
                  m_left   = int'(delay);
               end
            end
            m_quiet = m_tick ? 0 : ((m_quiet < LIMIT) ? m_quiet + 1 : LIMIT);
         end
      end

      start  = 1'b0;
      cancel = 1'b0;
      repeat (2) @(negedge Clock);

      total++;
      if (got_expired != exp_expired) begin
         bad++;
         $display("FAIL expired_count got=%0d want=%0d", got_expired, exp_expired);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
